// File: rtl/drone_pkg.sv
// Shared types and constants for the quad-motor offset mixer.
package drone_pkg;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned ACC_W      = 11;
    localparam int unsigned CENTRE     = 128;
    localparam int unsigned OFF_SHIFT  = 2;
    // Signed offset width; it must hold +32, which is the negation of -32.
    localparam int unsigned OFF_W      = DATA_W - OFF_SHIFT + 1;
    localparam int unsigned NUM_MOTORS = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ROLL  = 3'd1,
        ST_PITCH = 3'd2,
        ST_YAW   = 3'd3,
        ST_OUT   = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        AXIS_ROLL  = 2'd0,
        AXIS_PITCH = 2'd1,
        AXIS_YAW   = 2'd2
    } axis_e;

    typedef logic signed [OFF_W-1:0] off_t;

    typedef struct packed {
        off_t m1;
        off_t m2;
        off_t m3;
        off_t m4;
    } motor_offsets_t;

    // Saturate a signed accumulator into the unsigned motor command range.
    function automatic logic [DATA_W-1:0] clamp_cmd(input logic signed [ACC_W-1:0] acc);
        if (acc[ACC_W-1]) begin
            return '0;
        end else if (acc[ACC_W-2:DATA_W] != '0) begin
            return '1;
        end else begin
            return acc[DATA_W-1:0];
        end
    endfunction

endpackage

// File: rtl/axis_offset_gen.sv
// Converts one receiver axis value into the four signed motor offsets for that axis.
module axis_offset_gen
    import drone_pkg::*;
(
    input  axis_e               axis_sel,
    input  logic [DATA_W-1:0]   axis_val,
    output motor_offsets_t      offsets_c
);

    logic signed [DATA_W:0] diff;
    logic signed [DATA_W:0] half;
    off_t                   h_pos;
    off_t                   h_neg;

    assign diff  = $signed({1'b0, axis_val}) - $signed((DATA_W + 1)'(CENTRE));
    assign half  = diff >>> OFF_SHIFT;
    assign h_pos = OFF_W'(half);
    assign h_neg = -h_pos;

    // Sign pattern per axis, motor order (m1, m2, m3, m4).
    always_comb begin
        offsets_c = '0;
        unique case (axis_sel)
            AXIS_ROLL:  offsets_c = '{m1: h_pos, m2: h_neg, m3: h_neg, m4: h_pos};
            AXIS_PITCH: offsets_c = '{m1: h_pos, m2: h_pos, m3: h_neg, m4: h_neg};
            AXIS_YAW:   offsets_c = '{m1: h_pos, m2: h_neg, m3: h_pos, m4: h_neg};
            default:    offsets_c = '0;
        endcase
    end

endmodule

// File: rtl/offset_mixer_seq.sv
// Sequential quad mixer: one axis per cycle into four accumulators, then clamp and publish.
module offset_mixer_seq
    import drone_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              arm,
    input  logic [DATA_W-1:0] throttle_rec_val,
    input  logic [DATA_W-1:0] roll_rec_val,
    input  logic [DATA_W-1:0] pitch_rec_val,
    input  logic [DATA_W-1:0] yaw_rec_val,
    output logic [DATA_W-1:0] motor_1_cmd,
    output logic [DATA_W-1:0] motor_2_cmd,
    output logic [DATA_W-1:0] motor_3_cmd,
    output logic [DATA_W-1:0] motor_4_cmd,
    output logic              cmd_valid,
    output logic              busy
);

    state_e                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q [NUM_MOTORS];
    logic signed [ACC_W-1:0]  acc_d [NUM_MOTORS];
    logic [DATA_W-1:0]        motor_q [NUM_MOTORS];
    logic [DATA_W-1:0]        motor_d [NUM_MOTORS];
    logic [DATA_W-1:0]        roll_q, roll_d;
    logic [DATA_W-1:0]        pitch_q, pitch_d;
    logic [DATA_W-1:0]        yaw_q, yaw_d;
    logic                     arm_q, arm_d;
    logic                     cmd_valid_q, cmd_valid_d;
    logic                     busy_q, busy_d;

    axis_e                    axis_sel;
    logic [DATA_W-1:0]        axis_val;
    motor_offsets_t           offsets_c;
    logic signed [ACC_W-1:0]  off_ext [NUM_MOTORS];

    axis_offset_gen u_axis_offset_gen (
        .axis_sel  (axis_sel),
        .axis_val  (axis_val),
        .offsets_c (offsets_c)
    );

    assign off_ext[0] = ACC_W'($signed(offsets_c.m1));
    assign off_ext[1] = ACC_W'($signed(offsets_c.m2));
    assign off_ext[2] = ACC_W'($signed(offsets_c.m3));
    assign off_ext[3] = ACC_W'($signed(offsets_c.m4));

    // Next-state, datapath and output decode.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        motor_d     = motor_q;
        roll_d      = roll_q;
        pitch_d     = pitch_q;
        yaw_d       = yaw_q;
        arm_d       = arm_q;
        cmd_valid_d = 1'b0;
        axis_sel    = AXIS_ROLL;
        axis_val    = roll_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    roll_d  = roll_rec_val;
                    pitch_d = pitch_rec_val;
                    yaw_d   = yaw_rec_val;
                    arm_d   = arm;
                    for (int k = 0; k < NUM_MOTORS; k++) begin
                        acc_d[k] = ACC_W'(throttle_rec_val);
                    end
                    state_d = ST_ROLL;
                end
            end
            ST_ROLL: begin
                axis_sel = AXIS_ROLL;
                axis_val = roll_q;
                for (int k = 0; k < NUM_MOTORS; k++) begin
                    acc_d[k] = acc_q[k] + off_ext[k];
                end
                state_d = ST_PITCH;
            end
            ST_PITCH: begin
                axis_sel = AXIS_PITCH;
                axis_val = pitch_q;
                for (int k = 0; k < NUM_MOTORS; k++) begin
                    acc_d[k] = acc_q[k] + off_ext[k];
                end
                state_d = ST_YAW;
            end
            ST_YAW: begin
                axis_sel = AXIS_YAW;
                axis_val = yaw_q;
                for (int k = 0; k < NUM_MOTORS; k++) begin
                    acc_d[k] = acc_q[k] + off_ext[k];
                end
                state_d = ST_OUT;
            end
            ST_OUT: begin
                for (int k = 0; k < NUM_MOTORS; k++) begin
                    motor_d[k] = arm_q ? clamp_cmd(acc_q[k]) : '0;
                end
                cmd_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any pass in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            roll_q      <= '0;
            pitch_q     <= '0;
            yaw_q       <= '0;
            arm_q       <= 1'b0;
            cmd_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            for (int k = 0; k < NUM_MOTORS; k++) begin
                acc_q[k]   <= '0;
                motor_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            roll_q      <= roll_d;
            pitch_q     <= pitch_d;
            yaw_q       <= yaw_d;
            arm_q       <= arm_d;
            cmd_valid_q <= cmd_valid_d;
            busy_q      <= busy_d;
            for (int k = 0; k < NUM_MOTORS; k++) begin
                acc_q[k]   <= acc_d[k];
                motor_q[k] <= motor_d[k];
            end
        end
    end

    assign motor_1_cmd = motor_q[0];
    assign motor_2_cmd = motor_q[1];
    assign motor_3_cmd = motor_q[2];
    assign motor_4_cmd = motor_q[3];
    assign cmd_valid   = cmd_valid_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_offset_mixer_seq.sv
// Directed-vector bench for offset_mixer_seq with hand-computed motor commands.
module tb_offset_mixer_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic       arm;
    logic [7:0] thr, roll, pitch, yaw;
    logic [7:0] m1, m2, m3, m4;
    logic       cmd_valid;
    logic       busy;

    int checks = 0;
    int passed = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    offset_mixer_seq dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .arm              (arm),
        .throttle_rec_val (thr),
        .roll_rec_val     (roll),
        .pitch_rec_val    (pitch),
        .yaw_rec_val      (yaw),
        .motor_1_cmd      (m1),
        .motor_2_cmd      (m2),
        .motor_3_cmd      (m3),
        .motor_4_cmd      (m4),
        .cmd_valid        (cmd_valid),
        .busy             (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inputs(input logic a, input logic [7:0] t, input logic [7:0] r,
                              input logic [7:0] p, input logic [7:0] y);
        arm   = a;
        thr   = t;
        roll  = r;
        pitch = p;
        yaw   = y;
    endtask

    // Pulse start for one edge, then count edges until cmd_valid (-1 if it never comes).
    task automatic run_pass(input logic a, input logic [7:0] t, input logic [7:0] r,
                            input logic [7:0] p, input logic [7:0] y, output int lat);
        set_inputs(a, t, r, p, y);
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (cmd_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        set_inputs(1'b0, 8'd0, 8'd128, 8'd128, 8'd128);
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({m1, m2, m3, m4} !== 32'h0) $display("FAIL reset_cmds: got %0d %0d %0d %0d, want 0 0 0 0", m1, m2, m3, m4);
        else passed++;
        checks++;
        if ({cmd_valid, busy} !== 2'b00) $display("FAIL reset_flags: got valid=%b busy=%b, want 0 0", cmd_valid, busy);
        else passed++;
    endtask

    task automatic test_centre();
        int lat;
        set_inputs(1'b1, 8'd100, 8'd128, 8'd128, 8'd128);
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) $display("FAIL centre_busy: got %b, want 1", busy);
        else passed++;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (cmd_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat != 4) $display("FAIL centre_latency: got %0d, want 4", lat);
        else passed++;
        checks++;
        if ({m1, m2, m3, m4} !== {8'd100, 8'd100, 8'd100, 8'd100})
            $display("FAIL centre_cmds: got %0d %0d %0d %0d, want 100 100 100 100", m1, m2, m3, m4);
        else passed++;
        tick();
        checks++;
        if ({cmd_valid, busy} !== 2'b00) $display("FAIL centre_pulse_end: got valid=%b busy=%b, want 0 0", cmd_valid, busy);
        else passed++;
    endtask

    task automatic test_roll();
        int lat;
        run_pass(1'b1, 8'd100, 8'd200, 8'd128, 8'd128, lat);
        checks++;
        if (lat != 4) $display("FAIL roll_latency: got %0d, want 4", lat);
        else passed++;
        checks++;
        if ({m1, m2, m3, m4} !== {8'd118, 8'd82, 8'd82, 8'd118})
            $display("FAIL roll_cmds: got %0d %0d %0d %0d, want 118 82 82 118", m1, m2, m3, m4);
        else passed++;
        tick();
    endtask

    task automatic test_high_clamp();
        int lat;
        run_pass(1'b1, 8'd250, 8'd255, 8'd255, 8'd255, lat);
        checks++;
        if (lat != 4) $display("FAIL high_latency: got %0d, want 4", lat);
        else passed++;
        checks++;
        if ({m1, m2, m3, m4} !== {8'd255, 8'd219, 8'd219, 8'd219})
            $display("FAIL high_clamp_cmds: got %0d %0d %0d %0d, want 255 219 219 219", m1, m2, m3, m4);
        else passed++;
        tick();
    endtask

    task automatic test_low_clamp_and_disarm();
        int lat;
        run_pass(1'b1, 8'd10, 8'd0, 8'd128, 8'd128, lat);
        checks++;
        if (lat != 4) $display("FAIL low_latency: got %0d, want 4", lat);
        else passed++;
        checks++;
        if ({m1, m2, m3, m4} !== {8'd0, 8'd42, 8'd42, 8'd0})
            $display("FAIL low_clamp_cmds: got %0d %0d %0d %0d, want 0 42 42 0", m1, m2, m3, m4);
        else passed++;
        tick();
        run_pass(1'b0, 8'd10, 8'd0, 8'd128, 8'd128, lat);
        checks++;
        if (lat != 4) $display("FAIL disarm_latency: got %0d, want 4", lat);
        else passed++;
        checks++;
        if ({m1, m2, m3, m4} !== 32'h0)
            $display("FAIL disarm_cmds: got %0d %0d %0d %0d, want 0 0 0 0", m1, m2, m3, m4);
        else passed++;
        tick();
    endtask

    // Pitch 60 gives h=-17; yaw 127 gives h=-1 (arithmetic shift floors toward -inf).
    task automatic test_pitch_yaw();
        int lat;
        run_pass(1'b1, 8'd100, 8'd128, 8'd60, 8'd127, lat);
        checks++;
        if (lat != 4) $display("FAIL pitch_yaw_latency: got %0d, want 4", lat);
        else passed++;
        checks++;
        if ({m1, m2, m3, m4} !== {8'd82, 8'd84, 8'd116, 8'd118})
            $display("FAIL pitch_yaw_cmds: got %0d %0d %0d %0d, want 82 84 116 118", m1, m2, m3, m4);
        else passed++;
        tick();
    endtask

    task automatic test_busy_ignore();
        int lat;
        int extra_pulses;
        int busy_seen;
        set_inputs(1'b1, 8'd100, 8'd200, 8'd128, 8'd128);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        set_inputs(1'b0, 8'd50, 8'd0, 8'd0, 8'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = -1;
        for (int i = 3; i <= 10; i++) begin
            tick();
            if (cmd_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat != 4) $display("FAIL busy_ignore_latency: got %0d, want 4", lat);
        else passed++;
        checks++;
        if ({m1, m2, m3, m4} !== {8'd118, 8'd82, 8'd82, 8'd118})
            $display("FAIL busy_ignore_cmds: got %0d %0d %0d %0d, want 118 82 82 118", m1, m2, m3, m4);
        else passed++;
        extra_pulses = 0;
        busy_seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (cmd_valid === 1'b1) extra_pulses++;
            if (busy === 1'b1) busy_seen++;
        end
        checks++;
        if (extra_pulses != 0 || busy_seen != 0)
            $display("FAIL busy_ignore_queued: got pulses=%0d busy_cycles=%0d, want 0 0", extra_pulses, busy_seen);
        else passed++;
    endtask

    task automatic test_reset_mid_pass();
        int lat;
        int pulses;
        set_inputs(1'b1, 8'd100, 8'd128, 8'd128, 8'd128);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({cmd_valid, busy} !== 2'b00) $display("FAIL mid_reset_flags: got valid=%b busy=%b, want 0 0", cmd_valid, busy);
        else passed++;
        checks++;
        if ({m1, m2, m3, m4} !== 32'h0)
            $display("FAIL mid_reset_cmds: got %0d %0d %0d %0d, want 0 0 0 0", m1, m2, m3, m4);
        else passed++;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (cmd_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) $display("FAIL mid_reset_pulse: got %0d pulses, want 0", pulses);
        else passed++;
        run_pass(1'b1, 8'd100, 8'd200, 8'd128, 8'd128, lat);
        checks++;
        if (lat != 4 || {m1, m2, m3, m4} !== {8'd118, 8'd82, 8'd82, 8'd118})
            $display("FAIL mid_reset_fresh: got lat=%0d cmds %0d %0d %0d %0d, want 4 118 82 82 118",
                     lat, m1, m2, m3, m4);
        else passed++;
        tick();
    endtask

    task automatic test_back_to_back();
        int pulse_idx [2];
        logic [31:0] pulse_cmds [2];
        logic busy_at_first;
        int n;
        n = 0;
        pulse_idx[0] = -1;
        pulse_idx[1] = -1;
        pulse_cmds[0] = '0;
        pulse_cmds[1] = '0;
        busy_at_first = 1'bx;
        set_inputs(1'b1, 8'd100, 8'd200, 8'd128, 8'd128);
        start = 1'b1;
        tick();
        tick();
        set_inputs(1'b1, 8'd100, 8'd128, 8'd60, 8'd127);
        for (int i = 2; i <= 12; i++) begin
            if (cmd_valid === 1'b1 && n < 2) begin
                pulse_idx[n] = i - 1;
                pulse_cmds[n] = {m1, m2, m3, m4};
                if (n == 0) busy_at_first = busy;
                n++;
            end
            tick();
        end
        start = 1'b0;
        checks++;
        if (pulse_idx[0] != 4) $display("FAIL b2b_first_pulse: got edge %0d, want 4", pulse_idx[0]);
        else passed++;
        checks++;
        if (pulse_idx[1] != 9) $display("FAIL b2b_second_pulse: got edge %0d, want 9", pulse_idx[1]);
        else passed++;
        checks++;
        if (pulse_cmds[0] !== {8'd118, 8'd82, 8'd82, 8'd118})
            $display("FAIL b2b_first_cmds: got %h, want 76525276", pulse_cmds[0]);
        else passed++;
        checks++;
        if (pulse_cmds[1] !== {8'd82, 8'd84, 8'd116, 8'd118})
            $display("FAIL b2b_second_cmds: got %h, want 52547476", pulse_cmds[1]);
        else passed++;
        checks++;
        if (busy_at_first !== 1'b0) $display("FAIL b2b_idle_gap_busy: got %b, want 0", busy_at_first);
        else passed++;
        for (int i = 0; i < 8; i++) tick();
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        set_inputs(1'b0, 8'd0, 8'd128, 8'd128, 8'd128);
        test_reset();
        test_centre();
        test_roll();
        test_high_clamp();
        test_low_clamp_and_disarm();
        test_pitch_yaw();
        test_busy_ignore();
        test_reset_mid_pass();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
